// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline memory stage and a lane-strobed data memory port.
// Optional macro MEM_ACCESS_SPLIT_EN splits misaligned accesses into two beats instead of flagging them.
module mem_access_unit #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_req_valid,
   output logic                cpu_req_ready,
   input  logic                cpu_req_we,
   input  logic [1:0]          cpu_req_size,
   input  logic                cpu_req_unsigned,
   input  logic [ADDR_W-1:0]   cpu_req_addr,
   input  logic [XLEN-1:0]     cpu_req_wdata,
   output logic                cpu_rsp_valid,
   output logic [XLEN-1:0]     cpu_rsp_rdata,
   output logic                cpu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int LANES = XLEN / 8;
   localparam int OFF_W = $clog2(LANES);
   localparam int TW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam bit NO_DWORD = (XLEN == 32);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
   state_t state, state_n;

   logic                we_q, uns_q, err_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [XLEN-1:0]     wdata_q, beat0_q, beat1_q;
   logic [TW-1:0]       timer_q;
   logic                accept, set_err, clr_timer, inc_timer, cap0, cap1, timeout;
   logic [OFF_W-1:0]    req_off, off_q;

   assign req_off = cpu_req_addr[OFF_W-1:0];
   assign off_q   = addr_q[OFF_W-1:0];
   assign timeout = (MAX_WAIT > 0) && (timer_q == TW'(MAX_WAIT - 1));

   function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
      return (int'(off) + (1 << size)) > LANES;
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] size,
                                              input logic uns);
      logic [XLEN-1:0] mask;
      logic            sign;
      mask = '1;
      if ((8 << size) < XLEN) mask = (XLEN'(1) << (8 << size)) - XLEN'(1);
      sign = |(d & (mask ^ (mask >> 1)));
      return (uns || !sign) ? (d & mask) : (d | ~mask);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      set_err   = 1'b0;
      clr_timer = 1'b0;
      inc_timer = 1'b0;
      cap0      = 1'b0;
      cap1      = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req_valid) begin
               accept = 1'b1;
               if (NO_DWORD && cpu_req_size == 2'd3) begin
                  set_err = 1'b1;
                  state_n = RESP;
`ifdef MEM_ACCESS_SPLIT_EN
               end else begin
                  state_n = REQ0;
               end
`else
               end else if (misaligned(req_off, cpu_req_size)) begin
                  set_err = 1'b1;
                  state_n = RESP;
               end else begin
                  state_n = REQ0;
               end
`endif
            end
         end
         REQ0: if (mem_req_ready) begin
            clr_timer = 1'b1;
            state_n   = WAIT0;
         end
         WAIT0: begin
            if (mem_rsp_valid) begin
               cap0 = !we_q;
`ifdef MEM_ACCESS_SPLIT_EN
               state_n = misaligned(off_q, size_q) ? REQ1 : RESP;
`else
               state_n = RESP;
`endif
            end else if (timeout) begin
               set_err = 1'b1;
               state_n = RESP;
            end else begin
               inc_timer = 1'b1;
            end
         end
         REQ1: if (mem_req_ready) begin
            clr_timer = 1'b1;
            state_n   = WAIT1;
         end
         WAIT1: begin
            if (mem_rsp_valid) begin
               cap1    = !we_q;
               state_n = RESP;
            end else if (timeout) begin
               set_err = 1'b1;
               state_n = RESP;
            end else begin
               inc_timer = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         beat0_q <= '0;
         beat1_q <= '0;
         timer_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= cpu_req_we;
            uns_q   <= cpu_req_unsigned;
            size_q  <= cpu_req_size;
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            err_q   <= set_err;
         end else if (set_err) begin
            err_q <= 1'b1;
         end
         if (clr_timer)      timer_q <= '0;
         else if (inc_timer) timer_q <= timer_q + 1'b1;
         if (cap0) beat0_q <= mem_rdata;
         if (cap1) beat1_q <= mem_rdata;
      end
   end

   // Both beats are carved out of one double-width lane-shifted view of the access.
   logic [2*XLEN-1:0]  wide_wdata;
   logic [2*LANES-1:0] size_mask, wide_strb;
   logic [ADDR_W-1:0]  base;
   logic [XLEN-1:0]    rd_shift;
   logic               beat_hi;

   always_comb begin
      size_mask = '0;
      for (int i = 0; i < 2 * LANES; i++) size_mask[i] = (i < (1 << size_q));
   end

   assign wide_wdata = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
   assign wide_strb  = size_mask << off_q;
   assign base       = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign beat_hi    = (state == REQ1);
   assign rd_shift   = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});

   assign cpu_req_ready = (state == IDLE) && reset;
   assign mem_req_valid = (state == REQ0) || (state == REQ1);
   assign mem_we        = mem_req_valid && we_q;
   assign mem_addr      = !mem_req_valid ? '0 : (beat_hi ? base + ADDR_W'(LANES) : base);
   assign mem_wdata     = !mem_we ? '0 : (beat_hi ? wide_wdata[2*XLEN-1:XLEN] : wide_wdata[XLEN-1:0]);
   assign mem_wstrb     = !mem_we ? '0 : (beat_hi ? wide_strb[2*LANES-1:LANES] : wide_strb[LANES-1:0]);
   assign cpu_rsp_valid = (state == RESP);
   assign cpu_rsp_err   = (state == RESP) && err_q;
   assign cpu_rsp_rdata = (state == RESP && !err_q && !we_q) ? extend(rd_shift, size_q, uns_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32, MAX_WAIT=4): directed table, random traffic, reset abort.
module tb_mem_access_unit;

   localparam int XLEN = 32;
   localparam int ADDR_W = 32;
   localparam int MAX_WAIT = 4;
`ifdef MEM_ACCESS_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_req_unsigned;
   logic [1:0] cpu_req_size;
   logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_rsp_rdata;
   logic cpu_rsp_valid, cpu_rsp_err;
   logic mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0] mem_wstrb;

   always #5 clk = ~clk;

   mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
      .cpu_req_size(cpu_req_size), .cpu_req_unsigned(cpu_req_unsigned), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
      .cpu_rsp_err(cpu_rsp_err), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, wdata, b0, b1;
      int          stall, lat, drop;
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_cyc, e_nb;
      logic [31:0] e_addr0;
      logic [3:0]  e_strb0;
      logic [31:0] e_wd0;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc, nb;
      logic [31:0] addr [2];
      logic [3:0]  strb [2];
      logic [31:0] wd [2];
   } exp_t;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] act_rdata;
   logic        act_err;
   int          act_cyc, act_nb;
   logic        act_done;
   logic [31:0] act_addr [4];
   logic [3:0]  act_strb [4];
   logic [31:0] act_wd [4];
   logic        act_we [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, wdata, b0, b1, input int stall, lat, drop,
                               input logic [31:0] e_rdata, input logic e_err, input int e_cyc, e_nb,
                               input logic [31:0] e_addr0, input logic [3:0] e_strb0,
                               input logic [31:0] e_wd0);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.b0 = b0; v.b1 = b1; v.stall = stall; v.lat = lat; v.drop = drop;
      v.e_rdata = e_rdata; v.e_err = e_err; v.e_cyc = e_cyc; v.e_nb = e_nb;
      v.e_addr0 = e_addr0; v.e_strb0 = e_strb0; v.e_wd0 = e_wd0;
      return v;
   endfunction

   // Reference: what the access should look like on both buses, from byte offsets and sizes.
   function automatic exp_t model(input vec_t v);
      exp_t e;
      int off, nb, need;
      logic [63:0] wd64, rd64, mask;
      logic [7:0] sm;
      off = int'(v.addr % 4);
      nb = 1 << v.size;
      e.rdata = '0; e.err = 1'b0; e.cyc = 1; e.nb = 0;
      for (int k = 0; k < 2; k++) begin
         e.addr[k] = '0; e.strb[k] = '0; e.wd[k] = '0;
      end
      if (v.size == 2'd3 || (!SPLIT && off + nb > 4)) begin
         e.err = 1'b1;
         return e;
      end
      need = (off + nb > 4) ? 2 : 1;
      wd64 = {32'd0, v.wdata} << (8 * off);
      sm = 8'(((1 << nb) - 1) << off);
      e.cyc = 0;
      for (int k = 0; k < need; k++) begin
         e.nb++;
         e.addr[k] = (v.addr - 32'(off)) + 32'(4 * k);
         e.strb[k] = v.we ? sm[4*k +: 4] : 4'h0;
         e.wd[k] = v.we ? wd64[32*k +: 32] : 32'h0;
         e.cyc += v.stall + 1;
         if (v.drop == k) begin
            e.cyc += MAX_WAIT;
            e.err = 1'b1;
            break;
         end
         e.cyc += v.lat + 1;
      end
      e.cyc += 1;
      if (!e.err && !v.we) begin
         rd64 = {v.b1, v.b0} >> (8 * off);
         mask = (64'd1 << (8 * nb)) - 64'd1;
         rd64 = rd64 & mask;
         if (!v.uns && rd64[8*nb-1]) rd64 = rd64 | ~mask;
         e.rdata = rd64[31:0];
      end
      return e;
   endfunction

   // Issues one request and plays the memory side cycle by cycle, sampling on falling edges.
   task automatic run_access(input vec_t v);
      int in_beat, outstanding, left, cd, bidx;
      @(negedge clk);
      chk("idle_ready", cpu_req_ready, 1'b1);
      chk("rsp_quiet", cpu_rsp_valid, 1'b0);
      cpu_req_valid = 1'b1; cpu_req_we = v.we; cpu_req_size = v.size;
      cpu_req_unsigned = v.uns; cpu_req_addr = v.addr; cpu_req_wdata = v.wdata;
      act_done = 1'b0; act_nb = 0; act_cyc = -1; act_rdata = '0; act_err = 1'b0;
      in_beat = 0; outstanding = 0; left = 0; cd = 0; bidx = 0;
      for (int c = 1; c <= 60 && !act_done; c++) begin
         @(negedge clk);
         cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
         if (cpu_rsp_valid) begin
            act_done = 1'b1; act_cyc = c; act_rdata = cpu_rsp_rdata; act_err = cpu_rsp_err;
         end else begin
            if (outstanding != 0 && bidx != v.drop) begin
               if (cd == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rdata = (bidx == 0) ? v.b0 : v.b1;
                  outstanding = 0;
               end else cd--;
            end
            if (mem_req_valid) begin
               if (in_beat == 0) begin
                  bidx = act_nb;
                  if (act_nb < 4) begin
                     act_addr[act_nb] = mem_addr; act_strb[act_nb] = mem_wstrb;
                     act_wd[act_nb] = mem_wdata; act_we[act_nb] = mem_we;
                  end
                  act_nb++;
                  in_beat = 1;
                  left = v.stall;
               end else if (bidx < 4) begin
                  chk("stall_addr", mem_addr, act_addr[bidx]);
                  chk("stall_wdata", mem_wdata, act_wd[bidx]);
                  chk("stall_wstrb", mem_wstrb, act_strb[bidx]);
                  chk("stall_we", mem_we, act_we[bidx]);
               end
               if (left == 0) begin
                  mem_req_ready = 1'b1; in_beat = 0; outstanding = 1; cd = v.lat;
               end else left--;
            end
         end
      end
      chk("rsp_seen", act_done, 1'b1);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
   endtask

   task automatic check_model(input string tag, input vec_t v);
      exp_t e;
      e = model(v);
      chk({tag, "_m_rdata"}, act_rdata, e.rdata);
      chk({tag, "_m_err"}, act_err, e.err);
      chk({tag, "_m_cyc"}, act_cyc, e.cyc);
      chk({tag, "_m_beats"}, act_nb, e.nb);
      for (int k = 0; k < e.nb && k < act_nb; k++) begin
         chk({tag, "_m_addr"}, act_addr[k], e.addr[k]);
         chk({tag, "_m_strb"}, act_strb[k], e.strb[k]);
         chk({tag, "_m_wdata"}, act_wd[k], e.wd[k]);
         chk({tag, "_m_we"}, act_we[k], v.we);
      end
   endtask

   vec_t tbl [13];
   vec_t rv;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(1, 0, 0, 32'h1003, 32'h000000AB, 0, 0, 0, 0, -1,
                   32'h0, 0, 3, 1, 32'h1000, 4'b1000, 32'hAB000000);
      tbl[1]  = mk(0, 1, 0, 32'h2002, 0, 32'h80011234, 0, 0, 0, -1,
                   32'hFFFF8001, 0, 3, 1, 32'h2000, 4'h0, 32'h0);
      tbl[2]  = mk(0, 1, 1, 32'h2002, 0, 32'h80011234, 0, 0, 0, -1,
                   32'h00008001, 0, 3, 1, 32'h2000, 4'h0, 32'h0);
      tbl[3]  = mk(1, 2, 0, 32'h8000, 32'hCAFEF00D, 0, 0, 3, 0, -1,
                   32'h0, 0, 6, 1, 32'h8000, 4'hF, 32'hCAFEF00D);
      tbl[4]  = mk(0, 2, 0, 32'h4000, 0, 32'h11111111, 0, 0, 0, 0,
                   32'h0, 1, 6, 1, 32'h4000, 4'h0, 32'h0);
      tbl[5]  = mk(0, 3, 0, 32'h5000, 0, 32'h22222222, 0, 0, 0, -1,
                   32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0);
      tbl[6]  = SPLIT ? mk(0, 2, 0, 32'h3002, 0, 32'h55667788, 32'h11223344, 0, 0, -1,
                           32'h33445566, 0, 5, 2, 32'h3000, 4'h0, 32'h0)
                      : mk(0, 2, 0, 32'h3002, 0, 32'h55667788, 32'h11223344, 0, 0, -1,
                           32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0);
      tbl[7]  = SPLIT ? mk(1, 1, 0, 32'h7003, 32'h0000BEEF, 0, 0, 0, 0, -1,
                           32'h0, 0, 5, 2, 32'h7000, 4'b1000, 32'hEF000000)
                      : mk(1, 1, 0, 32'h7003, 32'h0000BEEF, 0, 0, 0, 0, -1,
                           32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0);
      tbl[8]  = mk(0, 0, 0, 32'h6001, 0, 32'h0000F500, 0, 0, 0, -1,
                   32'hFFFFFFF5, 0, 3, 1, 32'h6000, 4'h0, 32'h0);
      tbl[9]  = mk(0, 2, 0, 32'hA000, 0, 32'h12345678, 0, 0, 3, -1,
                   32'h12345678, 0, 6, 1, 32'hA000, 4'h0, 32'h0);
      tbl[10] = mk(0, 0, 1, 32'h6001, 0, 32'h0000F500, 0, 1, 1, -1,
                   32'h000000F5, 0, 5, 1, 32'h6000, 4'h0, 32'h0);
      tbl[11] = SPLIT ? mk(0, 1, 0, 32'h3003, 0, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0, 0,
                           32'h0, 1, 6, 1, 32'h3000, 4'h0, 32'h0)
                      : mk(0, 1, 0, 32'h3003, 0, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0, 0,
                           32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0);
      tbl[12] = SPLIT ? mk(0, 2, 0, 32'h3001, 0, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0, 1,
                           32'h0, 1, 8, 2, 32'h3000, 4'h0, 32'h0)
                      : mk(0, 2, 0, 32'h3001, 0, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0, 1,
                           32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0);

      cpu_req_valid = 0; cpu_req_we = 0; cpu_req_size = 0; cpu_req_unsigned = 0;
      cpu_req_addr = 0; cpu_req_wdata = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", cpu_req_ready, 1'b0);
      chk("rst_mem_valid", mem_req_valid, 1'b0);
      chk("rst_rsp_valid", cpu_rsp_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_access(tbl[i]);
         chk($sformatf("v%0d_rdata", i), act_rdata, tbl[i].e_rdata);
         chk($sformatf("v%0d_err", i), act_err, tbl[i].e_err);
         chk($sformatf("v%0d_cycles", i), act_cyc, tbl[i].e_cyc);
         chk($sformatf("v%0d_beats", i), act_nb, tbl[i].e_nb);
         if (tbl[i].e_nb > 0 && act_nb > 0) begin
            chk($sformatf("v%0d_addr0", i), act_addr[0], tbl[i].e_addr0);
            chk($sformatf("v%0d_strb0", i), act_strb[0], tbl[i].e_strb0);
            chk($sformatf("v%0d_wdata0", i), act_wd[0], tbl[i].e_wd0);
         end
         check_model($sformatf("v%0d", i), tbl[i]);
      end

      for (int i = 0; i < 200; i++) begin
         rv = mk($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 $urandom & 32'h0000FFFF, $urandom, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 3), -1, 0, 0, 0, 0, 0, 0, 0);
         if ($urandom_range(0, 9) == 0) rv.drop = $urandom_range(0, 1);
         run_access(rv);
         check_model($sformatf("r%0d", i), rv);
      end

      // Reset while waiting on beat 0, then a stray late response.
      @(negedge clk);
      cpu_req_valid = 1; cpu_req_we = 0; cpu_req_size = 2; cpu_req_addr = 32'h100;
      @(negedge clk);
      cpu_req_valid = 0;
      chk("abort_req_valid", mem_req_valid, 1'b1);
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      chk("abort_busy", cpu_req_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("abort_ready", cpu_req_ready, 1'b0);
      chk("abort_mem_valid", mem_req_valid, 1'b0);
      chk("abort_rsp_valid", cpu_rsp_valid, 1'b0);
      chk("abort_rsp_err", cpu_rsp_err, 1'b0);
      chk("abort_rsp_rdata", cpu_rsp_rdata, 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      chk("abort_mem_wstrb", mem_wstrb, 4'h0);
      @(negedge clk);
      reset = 1'b1;
      mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         chk("post_rst_rsp", cpu_rsp_valid, 1'b0);
         chk("post_rst_mem", mem_req_valid, 1'b0);
         chk("post_rst_ready", cpu_req_ready, 1'b1);
      end
      run_access(tbl[1]);
      check_model("after_reset", tbl[1]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the single-width data-memory handler between the pipeline's memory stage and the data memory port.
- Accepts one byte/half/word/dword load or store at a time over a valid/ready handshake.
- Drives a lane-strobed, aligned memory bus with wait states, per-access timeout and error reporting.
- Load results come back sign- or zero-extended to XLEN.

Parameters:
XLEN, 32, data width in bits; 32 or 64
ADDR_W, 32, byte-address width
MAX_WAIT, 15, max cycles waiting for mem_rsp_valid before timeout; 0 disables timeout

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
cpu_req_valid  in  1  access request
cpu_req_ready  out  1  unit idle, request accepted this cycle if valid
cpu_req_we  in  1  1 = store, 0 = load
cpu_req_size  in  2  0 byte, 1 half, 2 word, 3 dword
cpu_req_unsigned  in  1  zero-extend load result
cpu_req_addr  in  ADDR_W  byte address
cpu_req_wdata  in  XLEN  store data, right-justified
cpu_rsp_valid  out  1  one-cycle completion pulse
cpu_rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
cpu_rsp_err  out  1  misaligned, unsupported size or timeout
mem_req_valid  out  1  memory beat request
mem_req_ready  in  1  memory accepts beat
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  XLEN/8-aligned beat address
mem_wdata  out  XLEN  lane-positioned write data
mem_wstrb  out  XLEN/8  byte-lane enables
mem_rsp_valid  in  1  beat completion, reads and writes
mem_rdata  in  XLEN  read data, valid with mem_rsp_valid

Behaviour:
- Reset: FSM to IDLE; all outputs 0; internal request, timer and beat registers cleared.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, latch all request fields.
  - Compute off = addr mod (XLEN/8) and nbytes = 1<<size.
  - size=3 with XLEN=32 -> RESP with err=1; no memory beat.
  - Otherwise -> REQ0.
- cpu_req_ready is 0 in every state except IDLE.
- REQ0/REQ1:
  - mem_req_valid=1.
  - mem_addr, mem_we, mem_wdata and mem_wstrb stay stable until mem_req_ready.
  - On handshake, go to WAIT0/WAIT1 and clear the timer.
- Store lanes: mem_wdata = wdata << 8*off; mem_wstrb = ((1<<nbytes)-1) << off, truncated to XLEN/8 lanes.
- WAIT0/WAIT1:
  - mem_rsp_valid is accepted from the cycle after the request handshake.
  - On a load, capture mem_rdata.
  - The timer increments each cycle without a response.
  - Timer == MAX_WAIT (MAX_WAIT>0) -> RESP with err=1, rdata=0, no further beats.
- Load extract: (beat data >> 8*off), low nbytes kept, then sign-extended from bit 8*nbytes-1, or zero-extended if unsigned.
- RESP:
  - cpu_rsp_valid=1 for exactly one cycle with rdata and err.
  - Next state IDLE, so a back-to-back request is accepted one cycle later.
- Latency, aligned access, zero-wait memory:
  - Accept at T, mem_req_valid at T+1.
  - mem_rsp_valid at T+2, cpu_rsp_valid at T+3.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored, including late responses after reset.
- Misaligned access (off+nbytes > XLEN/8) is governed by the optional feature.
- Reset asserted mid-operation: immediate return to IDLE; no cpu_rsp_valid is produced for the aborted access.

Optional Feature:
Macro MEM_ACCESS_SPLIT_EN.
- Defined:
  - A misaligned access is split into two beats.
  - Beat0 at the aligned base covers lanes off..XLEN/8-1; beat1 at base+XLEN/8 covers the remaining lanes, with wdata shifted accordingly.
  - Load data = ({beat1,beat0} >> 8*off), then extended.
  - A timeout on beat0 skips beat1.
- Not defined:
  - A misaligned access goes IDLE -> RESP with err=1, rdata=0, and no mem_req_valid.
  - REQ1/WAIT1 are unreachable and may be optimised out.

Test Plan:
1. XLEN=32, store byte addr 0x1003, wdata 0x000000AB -> mem_addr 0x1000, mem_wstrb 0b1000, mem_wdata 0xAB000000; after mem_rsp_valid, cpu_rsp_valid=1, err=0, rdata=0.
2. Load half addr 0x2002, mem_rdata 0x80011234 -> rdata 0xFFFF8001 signed; 0x00008001 with cpu_req_unsigned=1; aligned latency exactly 3 cycles after accept.
3. mem_req_ready held low 3 cycles during a store -> mem_req_valid, mem_addr, mem_wdata, mem_wstrb unchanged all 3 cycles; one beat only.
4. MAX_WAIT=4, memory never asserts mem_rsp_valid -> cpu_rsp_valid with err=1, rdata=0 after 4 wait cycles; next request accepted the following cycle.
5. Load word addr 0x3002, beats return 0x55667788 then 0x11223344:
   - With MEM_ACCESS_SPLIT_EN: beats at 0x3000 and 0x3004, rdata 0x33445566.
   - Without it: no mem_req_valid, err=1.
6. reset driven low during WAIT0, then released; stray mem_rsp_valid pulsed -> all outputs 0, no cpu_rsp_valid, cpu_req_ready=1 after release.
